parallel_prefix_adder_pipelined: RTL and testbench
==================================================

// Module: parallel_prefix_adder_pipelined
// PURPOSE
//  Parametrised, pipelined Kogge-Stone adder/subtractor (1..128 bits) with valid/ready flow control.
//  Prefix levels are grouped into register stages, so timing closes at high clock rates for wide words.
//  Adds a subtract mode, signed-overflow flag, TAG sideband and full-throughput back-pressure.
//  Sits in the CPA library beside the combinational prefix adders; feeds MAC/ALU datapaths.
// PARAMETERS
//  BITS        8   operand width, 1..128
//  LVL_PER_STG 2   prefix levels between pipeline registers, 1..7
//  TAG_W       4   sideband tag width, >=1, carried unmodified alongside the operands
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block accepts a beat this cycle
//  op_sub     in   1        0: a+b+ci   1: a-b-ci (ci acts as borrow-in)
//  a          in   BITS     operand A
//  b          in   BITS     operand B
//  ci         in   1        carry-in / borrow-in
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts the result
//  s          out  BITS     sum/difference, mod 2^BITS
//  co         out  1        raw carry-out of the MSB (sub mode: 1 = no borrow)
//  ovf        out  1        signed overflow = carry into MSB XOR co
//  out_tag    out  TAG_W    tag of this result
// BEHAVIOUR
//  - D = max(1,$clog2(BITS)). NSTG = ceil(D/LVL_PER_STG). LATENCY = 1+NSTG cycles, accept edge to out_valid.
//  - Stage 0 register: b' = op_sub ? ~b : b; cin = op_sub ? ~ci : ci; g=a&b', p=a^b', alive=a|b'; registers p, g, alive, cin, tag.
//  - Stages 1..NSTG: each evaluates LVL_PER_STG Kogge-Stone levels, distance 2^k at level k, with cin folded into bit 0.
//    Stage NSTG also forms s[i] = p[i]^c[i], co, ovf, and registers all of them. Fewer levels in the last stage are fine.
//  - Handshake: a beat transfers on in_valid&&in_ready. A result transfers on out_valid&&out_ready.
//  - Per-stage valid bit v[k]. adv[k] = v[k] && (k==last ? out_ready : (!v[k+1] || adv[k+1])).
//    in_ready = !v[0] || adv[0], purely combinational from the v bits and out_ready.
//  - Full throughput: with out_ready held 1, one result per cycle with no bubbles.
//    Simultaneous accept on input and drain on output is legal every cycle.
//  - A stalled stage holds its data and valid. An empty stage downstream of a stall still fills, so bubbles collapse.
//  - Results emerge in acceptance order. out_tag always matches the beat that produced s.
//  - While out_valid=1 and out_ready=0, s/co/ovf/out_tag are stable.
//  - Inputs are ignored when in_valid=0. a/b/op_sub/ci/tag are sampled only on transfer.
//  - Reset (asynchronous assert, synchronous deassert expected): all v=0, out_valid=0, s=0, co=0, ovf=0, out_tag=0.
//    All pipeline data registers clear to 0. in_ready=1 the first cycle after reset.
//  - Reset mid-operation discards every in-flight beat. No result from before reset is ever presented.
//  - BITS=1: D=1, NSTG=1, LATENCY=2. co = g0 | (alive0 & cin).
//  - Wrap-around: s is modulo 2^BITS. co and ovf report the wrap.
// STRUCTURE
//  - Package ppa_pkg: MAX_BITS=128, function f_depth(bits), function f_nstg(depth,lps), typedef enum {PPA_ADD,PPA_SUB} ppa_op_e.
//    The existing cell_g / cell_ga prefix cells are reused unchanged.
//  - Sub-module ppa_ks_level #(BITS,DIST): one combinational Kogge-Stone level (g,alive in -> g,alive out).
//    It is instantiated D times through a generate loop; register insertion is decided by the level index.
//  - Pipeline control (valid/advance chain) lives in this module.
// TESTING
//  - BITS=8, LVL_PER_STG=2 (LATENCY 3): a=0x7F, b=0x01, ci=0, add -> s=0x80, co=0, ovf=1 on cycle 3.
//  - Same config: a=0x00, b=0x01, ci=0, sub -> s=0xFF, co=0 (borrow), ovf=0. a=0x05, b=0x03, ci=1, sub -> s=0x01, co=1.
//  - BITS=128, LVL_PER_STG=3 (LATENCY 4): a=all-ones, b=0, ci=1 -> s=0, co=1. Checks the full-width carry chain.
//  - Back-pressure: stream tags 0..9 with out_ready=0 for cycles 2-6, then 1.
//    No loss or duplication; in_ready drops once all stages are full; tags emerge in order 0..9.
//  - Reset asserted mid-stream with 3 beats in flight: out_valid=0 at once, outputs 0.
//    After release, the next accepted beat is the first result out, after exactly LATENCY cycles.
//  - Random sweep at BITS in {1,7,16,33,64}, LVL_PER_STG in {1,2,7}, random out_ready.
//    Compare s/co/ovf with the reference model {co,s} = a +/- b +/- ci.

Source files
------------

// File: rtl/ppa_pkg.sv
// Shared constants, depth helpers and operation encoding for the pipelined
// Kogge-Stone adder/subtractor.
package ppa_pkg;

  localparam int MAX_BITS = 128;

  typedef enum logic {
    PPA_ADD = 1'b0,
    PPA_SUB = 1'b1
  } ppa_op_e;

  // Number of prefix levels; a 1-bit word still gets one (pass-through) level.
  function automatic int f_depth(input int bits);
    return (bits <= 1) ? 1 : $clog2(bits);
  endfunction

  function automatic int f_nstg(input int depth, input int lps);
    return (depth + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/ppa_ks_level.sv
// One combinational Kogge-Stone level: combines each bit's (g, alive) group
// with the group DIST positions below it; low bits pass through unchanged.
module ppa_ks_level #(
  parameter int BITS = 8,
  parameter int DIST = 1
) (
  input  logic [BITS-1:0] g_i,
  input  logic [BITS-1:0] alive_i,
  output logic [BITS-1:0] g_o,
  output logic [BITS-1:0] alive_o
);

  for (genvar i = 0; i < BITS; i++) begin : g_bit
    if (i >= DIST) begin : g_cell
      assign g_o[i]     = g_i[i] | (alive_i[i] & g_i[i-DIST]);
      assign alive_o[i] = alive_i[i] & alive_i[i-DIST];
    end else begin : g_pass
      assign g_o[i]     = g_i[i];
      assign alive_o[i] = alive_i[i];
    end
  end

endmodule

// File: rtl/parallel_prefix_adder_pipelined.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Stage 0 registers bit-level g/p/alive; stages 1..NSTG each evaluate LVL_PER_STG prefix levels.
module parallel_prefix_adder_pipelined
  import ppa_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int LVL_PER_STG = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [BITS-1:0]  a,
  input  logic [BITS-1:0]  b,
  input  logic             ci,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  s,
  output logic             co,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int D    = f_depth(BITS);
  localparam int NSTG = f_nstg(D, LVL_PER_STG);

  if (BITS < 1 || BITS > MAX_BITS || LVL_PER_STG < 1 || TAG_W < 1) begin : g_param_check
    $error("parallel_prefix_adder_pipelined: unsupported parameter set");
  end

  ppa_op_e          op_e;
  logic [BITS-1:0]  b_eff;
  logic             cin_eff;
  logic             accept;

  logic [NSTG:0]    v_q;
  logic [NSTG:0]    v_d;
  logic [NSTG:0]    adv;

  logic [BITS-1:0]  p_q     [NSTG];
  logic [BITS-1:0]  g_q     [NSTG];
  logic [BITS-1:0]  alive_q [NSTG];
  logic [NSTG-1:0]  cin_q;
  logic [TAG_W-1:0] tag_q   [NSTG+1];

  logic [BITS-1:0]  s_q;
  logic [BITS-1:0]  s_d;
  logic             co_q;
  logic             co_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [BITS-1:0]  lvl_g_in  [D];
  logic [BITS-1:0]  lvl_a_in  [D];
  logic [BITS-1:0]  lvl_g_out [D];
  logic [BITS-1:0]  lvl_a_out [D];
  logic [BITS-1:0]  g_fold;
  logic [BITS:0]    carry;

  // Handshake: a beat moves on in_valid && in_ready, a result on out_valid && out_ready.
  // A stage advances when it is valid and the next stage is empty or itself advancing.
  always_comb begin
    logic down_free;
    logic adv_k;
    adv       = '0;
    down_free = out_ready;
    for (int k = NSTG; k >= 0; k--) begin
      adv_k     = v_q[k] & down_free;
      adv[k]    = adv_k;
      down_free = !v_q[k] | adv_k;
    end
  end

  always_comb begin
    v_d    = '0;
    v_d[0] = accept | (v_q[0] & !adv[0]);
    for (int k = 1; k <= NSTG; k++) begin
      v_d[k] = adv[k-1] | (v_q[k] & !adv[k]);
    end
  end

  assign op_e     = ppa_op_e'(op_sub);
  assign b_eff    = (op_e == PPA_SUB) ? ~b : b;
  assign cin_eff  = (op_e == PPA_SUB) ? ~ci : ci;
  assign in_ready = !v_q[0] | adv[0];
  assign accept   = in_valid & in_ready;

  // Carry-in behaves as a generate below bit 0, so fold it into g[0] before level 0.
  always_comb begin
    g_fold    = g_q[0];
    g_fold[0] = g_q[0][0] | (alive_q[0][0] & cin_q[0]);
  end

  for (genvar k = 0; k < D; k++) begin : g_lvl
    if (k == 0) begin : g_first
      assign lvl_g_in[k] = g_fold;
      assign lvl_a_in[k] = alive_q[0];
    end else if (k % LVL_PER_STG == 0) begin : g_stage_in
      assign lvl_g_in[k] = g_q[k / LVL_PER_STG];
      assign lvl_a_in[k] = alive_q[k / LVL_PER_STG];
    end else begin : g_chain
      assign lvl_g_in[k] = lvl_g_out[k-1];
      assign lvl_a_in[k] = lvl_a_out[k-1];
    end

    ppa_ks_level #(
      .BITS (BITS),
      .DIST (1 << k)
    ) u_level (
      .g_i     (lvl_g_in[k]),
      .alive_i (lvl_a_in[k]),
      .g_o     (lvl_g_out[k]),
      .alive_o (lvl_a_out[k])
    );
  end

  // carry[i] is the carry into bit i; carry[BITS] is the raw carry-out.
  assign carry = {lvl_g_out[D-1], cin_q[NSTG-1]};
  assign s_d   = p_q[NSTG-1] ^ carry[BITS-1:0];
  assign co_d  = carry[BITS];
  assign ovf_d = carry[BITS] ^ carry[BITS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      cin_q <= '0;
      s_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        p_q[k]     <= '0;
        g_q[k]     <= '0;
        alive_q[k] <= '0;
      end
      for (int k = 0; k <= NSTG; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      if (accept) begin
        p_q[0]     <= a ^ b_eff;
        g_q[0]     <= a & b_eff;
        alive_q[0] <= a | b_eff;
        cin_q[0]   <= cin_eff;
        tag_q[0]   <= in_tag;
      end
      for (int k = 1; k < NSTG; k++) begin
        if (adv[k-1]) begin
          p_q[k]     <= p_q[k-1];
          g_q[k]     <= lvl_g_out[k*LVL_PER_STG-1];
          alive_q[k] <= lvl_a_out[k*LVL_PER_STG-1];
          cin_q[k]   <= cin_q[k-1];
          tag_q[k]   <= tag_q[k-1];
        end
      end
      if (adv[NSTG-1]) begin
        s_q         <= s_d;
        co_q        <= co_d;
        ovf_q       <= ovf_d;
        tag_q[NSTG] <= tag_q[NSTG-1];
      end
    end
  end

  assign out_valid = v_q[NSTG];
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign out_tag   = tag_q[NSTG];

endmodule

// File: tb/tb_parallel_prefix_adder_pipelined.sv
// Scoreboard bench for the pipelined prefix adder: directed, back-pressure,
// mid-stream reset and randomized sweeps across widths and stage groupings.
module tb_parallel_prefix_adder_pipelined;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic for {co,s}; signed range test for ovf.
  function automatic void ref_model(input int bits, input logic sub, input logic [127:0] a,
                                    input logic [127:0] b, input logic ci,
                                    output logic [127:0] s, output logic co, output logic ovf);
    logic [129:0]        ua, ub, wide, mask;
    logic signed [129:0] one, sa, sb, cis, full, lim;
    ua   = {2'b00, a};
    ub   = {2'b00, b};
    mask = (130'd1 << bits) - 130'd1;
    wide = sub ? (ua - ub - 130'(ci)) : (ua + ub + 130'(ci));
    s    = 128'(wide & mask);
    co   = sub ? !wide[bits] : wide[bits];
    one  = 130'sd1;
    sa   = $signed(ua);
    sb   = $signed(ub);
    if (a[bits-1]) sa = sa - (one <<< bits);
    if (b[bits-1]) sb = sb - (one <<< bits);
    cis    = '0;
    cis[0] = ci;
    full = sub ? (sa - sb - cis) : (sa + sb + cis);
    lim  = one <<< (bits - 1);
    ovf  = (full >= lim) || (full < -lim);
  endfunction

  // ---------------- main instance: BITS=8, LVL_PER_STG=2 ----------------
  logic       m_iv = 1'b0, m_ir, m_op = 1'b0, m_ci = 1'b0, m_ov, m_or, m_co, m_ovf;
  logic [7:0] m_a = '0, m_b = '0, m_s;
  logic [3:0] m_it = '0, m_ot;
  logic       man_rdy = 1'b1, rnd_rdy = 1'b1, rdy_mode = 1'b0;
  logic [13:0] m_q[$];
  int          m_pops = 0;

  assign m_or = rdy_mode ? rnd_rdy : man_rdy;

  parallel_prefix_adder_pipelined #(.BITS(8), .LVL_PER_STG(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .op_sub(m_op),
    .a(m_a), .b(m_b), .ci(m_ci), .in_tag(m_it), .out_valid(m_ov), .out_ready(m_or),
    .s(m_s), .co(m_co), .ovf(m_ovf), .out_tag(m_ot)
  );

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst && m_ov) begin
      if (m_q.size() == 0) begin
        check("main_unexpected_out", 136'(m_ov), 136'(1'b0));
      end else begin
        check("main_result", 136'({m_ot, m_ovf, m_co, m_s}), 136'(m_q[0]));
        if (m_or) begin
          void'(m_q.pop_front());
          m_pops++;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic op, input logic [7:0] aa, input logic [7:0] bb,
                           input logic cc, input logic [3:0] tt, output int stalls);
    logic [127:0] es;
    logic         eco, eovf;
    stalls = 0;
    m_iv = 1'b1; m_op = op; m_a = aa; m_b = bb; m_ci = cc; m_it = tt;
    @(negedge clk);
    while (!m_ir && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!m_ir) begin
      m_iv = 1'b0;
      check("accept_timeout", 136'(m_ir), 136'(1'b1));
    end else begin
      ref_model(8, op, 128'(aa), 128'(bb), cc, es, eco, eovf);
      m_q.push_back({tt, eovf, eco, es[7:0]});
    end
    @(posedge clk);
    #1;
    m_iv = 1'b0;
  endtask

  task automatic measure_latency(input string name);
    int k;
    k = 1;
    while (!m_ov && k < 50) begin
      sync();
      k++;
    end
    check(name, 136'(k), 136'(LAT));
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (m_q.size() != 0 && g < 500) begin
      sync();
      g++;
    end
    check(name, 136'(m_q.size()), 136'(0));
  endtask

  // ---------------- sweep instances ----------------
  localparam int NCFG = 6;
  localparam int CFG_W [NCFG] = '{1, 7, 16, 33, 64, 128};
  localparam int CFG_L [NCFG] = '{1, 2, 7, 1, 2, 3};
  logic sweep_go   = 1'b0;
  int   sweep_done = 0;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
    localparam int W = CFG_W[gi];
    localparam int L = CFG_L[gi];
    logic         iv, ir, op, ci, ov, orr, co, ovf;
    logic [W-1:0] a, b, s;
    logic [3:0]   it, ot;
    logic [W+5:0] q[$];

    parallel_prefix_adder_pipelined #(.BITS(W), .LVL_PER_STG(L), .TAG_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .op_sub(op),
      .a(a), .b(b), .ci(ci), .in_tag(it), .out_valid(ov), .out_ready(orr),
      .s(s), .co(co), .ovf(ovf), .out_tag(ot)
    );

    always @(negedge clk) begin
      if (!rst && ov) begin
        if (q.size() == 0) begin
          check($sformatf("sw%0d_unexpected_out", W), 136'(ov), 136'(1'b0));
        end else begin
          check($sformatf("sw%0d_result", W), 136'({ot, ovf, co, s}), 136'(q[0]));
          if (orr) void'(q.pop_front());
        end
      end
    end

    initial begin
      logic [127:0] ra, rb, es;
      logic         eco, eovf;
      int           sent, guard;
      iv = 1'b0; op = 1'b0; ci = 1'b0; a = '0; b = '0; it = '0; orr = 1'b1;
      wait (sweep_go);
      sync();
      sent  = 0;
      guard = 0;
      while (sent < 150 && guard < 4000) begin
        guard++;
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
          0: ra = '1;
          1: rb = '1;
          2: ra = '0;
          3: begin ra = '1; rb = '1; end
          default: ;
        endcase
        if (sent == 0) begin
          ra = '1;
          rb = '0;
        end
        iv  = ($urandom_range(0, 3) != 0) || (sent == 0);
        op  = (sent == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        ci  = (sent == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        a   = ra[W-1:0];
        b   = rb[W-1:0];
        it  = 4'(sent);
        orr = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (iv && ir) begin
          ref_model(W, op, 128'(a), 128'(b), ci, es, eco, eovf);
          q.push_back({it, eovf, eco, es[W-1:0]});
          sent++;
        end
        sync();
      end
      iv    = 1'b0;
      orr   = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 500) begin
        sync();
        guard++;
      end
      check($sformatf("sw%0d_drain", W), 136'(q.size()), 136'(0));
      check($sformatf("sw%0d_sent", W), 136'(sent), 136'(150));
      sweep_done++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int st, tot, base, g;
    logic saw_low;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 136'(m_ov), 136'(1'b0));
    check("rst_s", 136'(m_s), 136'(8'h00));
    check("rst_co", 136'(m_co), 136'(1'b0));
    check("rst_ovf", 136'(m_ovf), 136'(1'b0));
    check("rst_out_tag", 136'(m_ot), 136'(4'h0));
    check("rst_in_ready", 136'(m_ir), 136'(1'b1));
    sync();

    // Directed arithmetic corners
    send_beat(1'b0, 8'h7F, 8'h01, 1'b0, 4'h1, st);
    measure_latency("lat_add");
    wait_drain("drain_add");
    send_beat(1'b1, 8'h00, 8'h01, 1'b0, 4'h2, st);
    send_beat(1'b1, 8'h05, 8'h03, 1'b1, 4'h3, st);
    send_beat(1'b0, 8'hFF, 8'hFF, 1'b1, 4'h4, st);
    send_beat(1'b1, 8'h80, 8'h01, 1'b0, 4'h5, st);
    wait_drain("drain_directed");

    // Full throughput with out_ready held high
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 4'(i), st);
      tot += st;
    end
    check("throughput_stalls", 136'(tot), 136'(0));
    wait_drain("drain_throughput");

    // Back-pressure: out_ready low for cycles 2..6
    saw_low = 1'b0;
    base    = m_pops;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_beat(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 4'(i), st);
      end
      begin
        man_rdy = 1'b1;
        sync();
        man_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1 man_rdy = 1'b1;
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (!m_ir) saw_low = 1'b1;
        end
      end
    join
    sync();
    wait_drain("bp_drain");
    check("bp_in_ready_dropped", 136'(saw_low), 136'(1'b1));
    check("bp_result_count", 136'(m_pops - base), 136'(10));

    // Reset with three beats in flight
    man_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      send_beat(1'b0, 8'($urandom), 8'($urandom), 1'b0, 4'(8 + i), st);
    @(negedge clk);
    check("midrst_pre_valid", 136'(m_ov), 136'(1'b1));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 136'(m_ov), 136'(1'b0));
    check("midrst_s", 136'(m_s), 136'(8'h00));
    check("midrst_co", 136'(m_co), 136'(1'b0));
    check("midrst_ovf", 136'(m_ovf), 136'(1'b0));
    check("midrst_out_tag", 136'(m_ot), 136'(4'h0));
    m_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    man_rdy = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 136'(m_ir), 136'(1'b1));
    sync();
    send_beat(1'b0, 8'h3C, 8'h42, 1'b1, 4'hE, st);
    measure_latency("midrst_latency");
    wait_drain("midrst_drain");

    // Randomized traffic with random out_ready
    rdy_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) sync();
      send_beat(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 4'($urandom), st);
    end
    rdy_mode = 1'b0;
    wait_drain("rand_drain");

    // Width / grouping sweep
    sweep_go = 1'b1;
    g = 0;
    while (sweep_done < NCFG && g < 20000) begin
      sync();
      g++;
    end
    check("sweep_done", 136'(sweep_done), 136'(NCFG));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
